barrel_shift32: RTL and testbench
=================================

// Module: barrel_shift32
// PURPOSE
//  32-bit logical barrel shifter with registered output; shift amount and direction select per cycle.
//  Serves the ALU's SLL/SRL operations (shift amount = second ALU operand).
//  Combinational 5-stage log shifter feeding one output register.
// PARAMETERS
//  none; data width fixed at 32 via shared width constants (see STRUCTURE).
// PORTS
//  CLK   in   1   clock; output register updates on rising edge
//  RST   in   1   reset, asynchronous, active-low
//  D     in   32  data to shift
//  S     in   32  shift amount, unsigned, full 32-bit operand
//  LnR   in   1   direction: 1 = shift left, 0 = shift right
//  Y     out  32  registered shift result
// BEHAVIOUR
//  - One clock; RST asynchronous active-low. RST=0 forces Y=32'h0 immediately,
//    independent of CLK; held while low. First capture on the first rising CLK after RST rises.
//  - Rising CLK with RST=1: Y <= f(D,S,LnR) sampled that edge. Latency 1 cycle; no enable, no handshake.
//  - f: LnR=1 -> D << S; LnR=0 -> D >> S. Logical only: vacated bits zero-filled,
//    no sign extension, no rotate.
//  - Amount uses S[4:0] for the stage muxes. If any of S[31:5] is set (S >= 32) the
//    result is 32'h0 in either direction (e.g. S=47 -> 0, never S mod 32).
//  - S=0: Y = D for either LnR value.
//  - S=31: only D[0] survives (left, at bit 31) or D[31] (right, at bit 0).
//  - LnR or S X/Z: no defined result required; bench does not drive them.
//  - Inputs changing between edges have no effect on Y until the next edge.
//  - Reset asserted mid-stream: Y=0 at once; pending input is discarded.
// STRUCTURE
//  - Shared definitions header (prj_definition.v): DATA_WIDTH=32, SHAMT_WIDTH=5. Shifter-local
//    constants stay out of it.
//  - Sub-module shift_stage32 (parameter DIST): 32-bit 2:1 mux choosing in vs in shifted by
//    DIST in the LnR direction. Instantiate five of them with DIST = 1,2,4,8,16, controlled by S[0]..S[4].
//  - Out-of-range detect: OR-reduce S[31:5]; zero-select mux after stage 16.
//  - One 32-bit register with async active-low clear drives Y.
//  - Combinational path purely structural or continuous assign; no latches.
// TESTING
//  - Reset: RST=0 with any D/S -> Y=0 without a CLK edge; RST=1 then edge with D=5,S=6,LnR=1 -> Y=32'h140.
//  - Right shifts: D=32'h15,S=0 -> 32'h15; D=5,S=1 -> 2; D=32'h15,S=8 -> 0 (all bits shifted out).
//  - Left shifts: D=5,S=3 -> 32'h28; D=1,S=15 -> 32'h8000; D=1,S=31 -> 32'h8000_0000.
//  - Out of range: D=32'h15,S=47,LnR=1 -> 0; D=32'hFFFF_FFFF,S=32,LnR=0 -> 0; S=32'h8000_0001 -> 0.
//  - Latency/hold: change D/S/LnR mid-cycle -> Y unchanged until next rising CLK.
//    Assert RST between edges -> Y=0 at once.
//  - Sweep: random D, S in 0..40, both LnR values; compare against a reference model with a
//    1-cycle delay. Include S=0 and D=0.

Source files
------------

// File: rtl/barrel_shift32_pkg.sv
// Shared width constants and small helpers for the 32-bit logical barrel shifter.
package barrel_shift32_pkg;

    // Datapath width and the number of shift-amount bits that drive the stage muxes.
    localparam int DATA_WIDTH  = 32;
    localparam int SHAMT_WIDTH = 5;

    typedef logic [DATA_WIDTH-1:0] word_t;

    // Direction encoding of the LnR input.
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // True when any amount bit above the stage-controlled field is set, i.e. amount >= DATA_WIDTH.
    function automatic logic amountOutOfRange(input word_t amount);
        return |amount[DATA_WIDTH-1:SHAMT_WIDTH];
    endfunction

endpackage : barrel_shift32_pkg

// File: rtl/shift_stage32.sv
// One stage of the logarithmic shifter: passes the word through, or shifts it by DIST
// positions toward the selected direction with zero fill.
module shift_stage32
    import barrel_shift32_pkg::*;
#(
    parameter int DIST = 1
) (
    input  logic  sel,
    input  logic  lnR,
    input  word_t inData,
    output word_t outData
);

    // Select between the unshifted word and the zero-filled shift by DIST.
    always_comb begin
        outData = inData;
        if (sel) begin
            if (lnR == DIR_LEFT) begin
                outData = inData << DIST;
            end else begin
                outData = inData >> DIST;
            end
        end else begin
            outData = inData;
        end
    end

endmodule : shift_stage32

// File: rtl/barrel_shift32.sv
// 32-bit logical barrel shifter: five binary-weighted stages, an out-of-range zero
// select for amounts >= 32, and a single output register cleared asynchronously.
module barrel_shift32
    import barrel_shift32_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] S,
    input  logic                  LnR,
    output logic [DATA_WIDTH-1:0] Y
);

    word_t stage1_s;
    word_t stage2_s;
    word_t stage4_s;
    word_t stage8_s;
    word_t stage16_s;
    word_t shifted_s;
    logic  outOfRange_s;
    word_t yReg_r;

    // Each stage is steered by one bit of the amount; the chain composes any 0..31 shift.
    shift_stage32 #(.DIST(1)) uStage1 (
        .sel     (S[0]),
        .lnR     (LnR),
        .inData  (D),
        .outData (stage1_s)
    );

    shift_stage32 #(.DIST(2)) uStage2 (
        .sel     (S[1]),
        .lnR     (LnR),
        .inData  (stage1_s),
        .outData (stage2_s)
    );

    shift_stage32 #(.DIST(4)) uStage4 (
        .sel     (S[2]),
        .lnR     (LnR),
        .inData  (stage2_s),
        .outData (stage4_s)
    );

    shift_stage32 #(.DIST(8)) uStage8 (
        .sel     (S[3]),
        .lnR     (LnR),
        .inData  (stage4_s),
        .outData (stage8_s)
    );

    shift_stage32 #(.DIST(16)) uStage16 (
        .sel     (S[4]),
        .lnR     (LnR),
        .inData  (stage8_s),
        .outData (stage16_s)
    );

    // Amounts of 32 or more shift every bit out, so the result is forced to zero
    // rather than wrapping to amount mod 32.
    assign outOfRange_s = amountOutOfRange(S);

    // Zero-select after the last stage for out-of-range amounts.
    always_comb begin
        shifted_s = stage16_s;
        if (outOfRange_s) begin
            shifted_s = {DATA_WIDTH{1'b0}};
        end else begin
            shifted_s = stage16_s;
        end
    end

    // Output register: captures the shift result each rising edge, cleared at once by reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            yReg_r <= {DATA_WIDTH{1'b0}};
        end else begin
            yReg_r <= shifted_s;
        end
    end

    assign Y = yReg_r;

endmodule : barrel_shift32

// File: tb/tb_barrel_shift32.sv
// Self-checking bench for barrel_shift32: reset behaviour, directed vector table,
// hold/latency and mid-cycle reset sequences, and a randomized sweep against an
// arithmetic reference model.
module tb_barrel_shift32;

    logic        CLK;
    logic        RST;
    logic [31:0] D;
    logic [31:0] S;
    logic        LnR;
    logic [31:0] Y;

    int checks   = 0;
    int failures = 0;

    barrel_shift32 dut (
        .CLK (CLK),
        .RST (RST),
        .D   (D),
        .S   (S),
        .LnR (LnR),
        .Y   (Y)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [31:0] d;
        logic [31:0] s;
        logic        lnr;
        logic [31:0] exp;
    } vec_t;

    // Reference: a left shift is multiplication by 2^s modulo 2^32, a right shift is
    // integer division by 2^s; any amount of 32 or more leaves nothing.
    function automatic logic [31:0] refShift(input logic [31:0] d, input logic [31:0] s,
                                             input logic lnr);
        logic [63:0] wide;
        if (s >= 32'd32) return 32'h0;
        if (lnr) begin
            wide = {32'h0, d} * (64'd1 << s);
            return wide[31:0];
        end
        return d / (32'd1 << s);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got Y=%08h expected %08h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, let one rising edge capture, sample 1 time unit later.
    task automatic applyCheck(input string name, input logic [31:0] d, input logic [31:0] s,
                              input logic lnr, input logic [31:0] exp);
        @(negedge CLK);
        D = d; S = s; LnR = lnr;
        @(posedge CLK);
        #1;
        check(name, Y, exp);
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] rd;
        logic [31:0] rs;
        logic        rl;

        vecs.push_back('{"r_s0",      32'h15,        32'd0,          1'b0, 32'h15});
        vecs.push_back('{"r_5s1",     32'h5,         32'd1,          1'b0, 32'h2});
        vecs.push_back('{"r_out8",    32'h15,        32'd8,          1'b0, 32'h0});
        vecs.push_back('{"l_s0",      32'h15,        32'd0,          1'b1, 32'h15});
        vecs.push_back('{"l_5s3",     32'h5,         32'd3,          1'b1, 32'h28});
        vecs.push_back('{"l_1s15",    32'h1,         32'd15,         1'b1, 32'h8000});
        vecs.push_back('{"l_1s31",    32'h1,         32'd31,         1'b1, 32'h8000_0000});
        vecs.push_back('{"l_ff_s31",  32'hFFFF_FFFE, 32'd31,         1'b1, 32'h0});
        vecs.push_back('{"r_ff_s31",  32'hFFFF_FFFF, 32'd31,         1'b0, 32'h1});
        vecs.push_back('{"r_msb_s31", 32'h8000_0000, 32'd31,         1'b0, 32'h1});
        vecs.push_back('{"l_s47",     32'h15,        32'd47,         1'b1, 32'h0});
        vecs.push_back('{"r_s32",     32'hFFFF_FFFF, 32'd32,         1'b0, 32'h0});
        vecs.push_back('{"l_s8000_1", 32'hFFFF_FFFF, 32'h8000_0001,  1'b1, 32'h0});
        vecs.push_back('{"r_s8000_1", 32'hFFFF_FFFF, 32'h8000_0001,  1'b0, 32'h0});
        vecs.push_back('{"r_neg",     32'h8000_0000, 32'd4,          1'b0, 32'h0800_0000});
        vecs.push_back('{"l_s16",     32'h0000_ABCD, 32'd16,         1'b1, 32'hABCD_0000});

        // Reset asserted from time zero with nonzero inputs: output must be zero.
        RST = 1'b0; D = 32'hDEAD_BEEF; S = 32'd3; LnR = 1'b1;
        #2;
        check("rst_init", Y, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        check("rst_held", Y, 32'h0);

        // First capture after reset release.
        @(negedge CLK);
        RST = 1'b1;
        applyCheck("rst_first", 32'd5, 32'd6, 1'b1, 32'h140);

        // Directed vector table.
        foreach (vecs[i]) applyCheck(vecs[i].name, vecs[i].d, vecs[i].s, vecs[i].lnr, vecs[i].exp);

        // Hold: inputs changed mid-cycle must not reach Y before the next rising edge.
        applyCheck("hold_base", 32'h5, 32'd3, 1'b1, 32'h28);
        #2;
        D = 32'hFFFF_FFFF; S = 32'd1; LnR = 1'b0;
        #1;
        check("hold_mid", Y, 32'h28);
        @(negedge CLK);
        check("hold_neg", Y, 32'h28);
        @(posedge CLK);
        #1;
        check("hold_next", Y, 32'h7FFF_FFFF);

        // Reset between edges clears Y immediately and discards the pending input.
        #2;
        RST = 1'b0;
        #1;
        check("rst_mid", Y, 32'h0);
        @(posedge CLK);
        #1;
        check("rst_mid_edge", Y, 32'h0);
        @(negedge CLK);
        RST = 1'b1;
        applyCheck("rst_recover", 32'h1, 32'd4, 1'b1, 32'h10);

        // Randomized sweep, including explicit zero data and zero amount cases.
        for (int i = 0; i < 300; i++) begin
            rd = $urandom();
            rs = 32'($urandom_range(40, 0));
            rl = 1'($urandom_range(1, 0));
            if (i % 17 == 0) rd = 32'h0;
            if (i % 13 == 0) rs = 32'd0;
            applyCheck("sweep", rd, rs, rl, refShift(rd, rs, rl));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_barrel_shift32
